c5g_housekeeping_i2c_bus_mux: RTL

Routes the single housekeeping I2C master onto one of four downstream I2C segments, selected by the 2-bit device-select PIO output (`sel`). Sits directly downstream of the device-select PIO and upstream of the board's open-drain pad buffers. Selection changes are applied only when the active segment is idle, with a guard interval in which all segments are released, so a switch never truncates a transfer or glitches SCL/SDA.

---
 rtl/c5g_housekeeping_i2c_bus_mux.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/c5g_housekeeping_i2c_bus_mux.sv
// c5g_housekeeping_i2c_bus_mux
// Connects the housekeeping I2C master to one of four downstream segments.
// A segment change waits until the active segment has been quiet long enough
// to be sure no transfer is in flight. It then releases every segment for a
// short guard interval and only then reconnects on the newly requested one.
// Handshake note: there is no valid/ready pair here. `sel` is a level
// request, and `busy` is high from the first clock after `sel` differs from
// `active_sel` until the reconnect completes (or the request is withdrawn).
module c5g_housekeeping_i2c_bus_mux #(
    parameter int IDLE_CYCLES  = 512,
    parameter int GUARD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] sel,
    input  logic       m_scl_oe,
    input  logic       m_sda_oe,
    output logic       m_scl_in,
    output logic       m_sda_in,
    input  logic [3:0] bus_scl_in,
    input  logic [3:0] bus_sda_in,
    output logic [3:0] bus_scl_oe,
    output logic [3:0] bus_sda_oe,
    output logic [1:0] active_sel,
    output logic       busy
);

    // Counter widths; a 1-cycle parameter still gets a 1-bit counter.
    localparam int IDLE_W  = (IDLE_CYCLES  > 1) ? $clog2(IDLE_CYCLES)  : 1;
    localparam int GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    // Terminal counts: the final idle cycle and the final guard cycle.
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_CONNECTED = 2'd0,
        ST_WAIT_IDLE = 2'd1,
        ST_ISOLATE   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [IDLE_W-1:0]  idle_cnt_next;
    logic [GUARD_W-1:0] guard_cnt;
    logic [GUARD_W-1:0] guard_cnt_next;
    logic [1:0]         active_next;

    // Pad levels after two flops. A released (high) line is the safe
    // default, so the synchronisers reset to 1.
    logic [3:0] scl_meta;
    logic [3:0] scl_sync;
    logic [3:0] sda_meta;
    logic [3:0] sda_sync;

    // The active segment looks idle when both of its lines read high and
    // the master is not pulling either line low.
    logic seg_idle;

    assign seg_idle = scl_sync[active_sel] & sda_sync[active_sel] & ~m_scl_oe & ~m_sda_oe;

    // Two-flop synchronisers for all eight asynchronous pad inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_meta <= 4'b1111;
            scl_sync <= 4'b1111;
            sda_meta <= 4'b1111;
            sda_sync <= 4'b1111;
        end else begin
            scl_meta <= bus_scl_in;
            scl_sync <= scl_meta;
            sda_meta <= bus_sda_in;
            sda_sync <= sda_meta;
        end
    end

    // State register, along with the counters and the connected segment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_CONNECTED;
            idle_cnt   <= '0;
            guard_cnt  <= '0;
            active_sel <= 2'd0;
        end else begin
            state      <= state_next;
            idle_cnt   <= idle_cnt_next;
            guard_cnt  <= guard_cnt_next;
            active_sel <= active_next;
        end
    end

    // Next-state logic. Each counter is cleared whenever its state is left,
    // so neither counter ever wraps.
    always_comb begin
        state_next     = state;
        idle_cnt_next  = '0;
        guard_cnt_next = '0;
        active_next    = active_sel;
        case (state)
            ST_CONNECTED: begin
                if (sel != active_sel) begin
                    state_next = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (sel == active_sel) begin
                    // The request was withdrawn, so stay on this segment.
                    state_next = ST_CONNECTED;
                end else if (seg_idle) begin
                    if (idle_cnt == IDLE_LAST) begin
                        state_next = ST_ISOLATE;
                    end else begin
                        idle_cnt_next = idle_cnt + 1'b1;
                    end
                end
                // Any cycle with activity restarts the quiet-time count.
            end
            ST_ISOLATE: begin
                if (guard_cnt == GUARD_LAST) begin
                    // Use whatever sel holds now, even the old segment.
                    active_next = sel;
                    state_next  = ST_CONNECTED;
                end else begin
                    guard_cnt_next = guard_cnt + 1'b1;
                end
            end
            default: begin
                state_next = ST_CONNECTED;
            end
        endcase
    end

    // Output routing. The master drive path stays combinational so that no
    // latency is added to SCL/SDA. Isolation releases every segment and
    // shows the master an idle bus.
    always_comb begin
        bus_scl_oe = 4'b0000;
        bus_sda_oe = 4'b0000;
        m_scl_in   = 1'b1;
        m_sda_in   = 1'b1;
        busy       = 1'b0;
        case (state)
            ST_CONNECTED: begin
                bus_scl_oe[active_sel] = m_scl_oe;
                bus_sda_oe[active_sel] = m_sda_oe;
                m_scl_in               = scl_sync[active_sel];
                m_sda_in               = sda_sync[active_sel];
            end
            ST_WAIT_IDLE: begin
                bus_scl_oe[active_sel] = m_scl_oe;
                bus_sda_oe[active_sel] = m_sda_oe;
                m_scl_in               = scl_sync[active_sel];
                m_sda_in               = sda_sync[active_sel];
                busy                   = 1'b1;
            end
            ST_ISOLATE: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
